// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle signed restoring divider with start/busy/done handshake
module seq_signed_divider #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic [N_WIDTH-1:0] quot,
  output logic [D_WIDTH-1:0] rem,
  output logic               busy,
  output logic               done,
  output logic               dz,
  output logic               ovf
);
  localparam int CW = $clog2(N_WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [N_WIDTH-1:0] a_q, a_d, quot_q, quot_d;
  logic [D_WIDTH-1:0] b_q, b_d, lo_q, lo_d, rem_q, rem_d;
  logic [D_WIDTH:0] r_q, r_d, sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sq_q, sq_d, sr_q, sr_d, z_q, z_d, dz_q, dz_d, ovf_q, ovf_d, ge;
  // next-state, one shift-subtract step per CALC cycle, sign fix-up in FIX
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    lo_d = lo_q;
    cnt_d = cnt_q;
    sq_d = sq_q;
    sr_d = sr_q;
    z_d = z_q;
    quot_d = quot_q;
    rem_d = rem_q;
    dz_d = dz_q;
    ovf_d = ovf_q;
    sh = {r_q[D_WIDTH-1:0], a_q[N_WIDTH-1]};
    ge = r_q[D_WIDTH] | (sh >= {1'b0, b_q});
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        a_d = dividend[N_WIDTH-1] ? -dividend : dividend;
        b_d = divisor[D_WIDTH-1] ? -divisor : divisor;
        lo_d = dividend[D_WIDTH-1:0];
        sq_d = dividend[N_WIDTH-1] ^ divisor[D_WIDTH-1];
        sr_d = dividend[N_WIDTH-1];
        z_d = divisor == '0;
        r_d = '0;
        cnt_d = '0;
      end
      CALC: begin
        r_d = ge ? sh - {1'b0, b_q} : sh;
        a_d = {a_q[N_WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N_WIDTH - 1)) ? FIX : CALC;
      end
      FIX: begin
        quot_d = z_q ? '1 : (sq_q ? -a_q : a_q);
        rem_d = z_q ? lo_q : (sr_q ? -r_q[D_WIDTH-1:0] : r_q[D_WIDTH-1:0]);
        dz_d = z_q;
        ovf_d = !z_q && !sq_q && a_q[N_WIDTH-1];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      z_q <= 1'b0;
      quot_q <= '0;
      rem_q <= '0;
      dz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      z_q <= z_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      dz_q <= dz_d;
      ovf_q <= ovf_d;
    end
  end
  assign quot = quot_q;
  assign rem = rem_q;
  assign dz = dz_q;
  assign ovf = ovf_q;
  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = state_q == DONE;
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed self-checking bench for seq_signed_divider
module tb_seq_signed_divider;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [15:0] quot;
  logic [7:0] rem;
  logic busy, done, dz, ovf;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  seq_signed_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quot(quot), .rem(rem), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one division from IDLE; inj>0 pulses a competing start so it is seen at edge k+inj
  task automatic run(input string tag, input logic [15:0] a, input logic [7:0] b,
                     input logic [15:0] eq, input logic [7:0] er, input logic edz,
                     input logic eovf, input int inj);
    int n = 0, bc = 0;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!done && n < 40) begin
      bc += int'(busy);
      start = (n == inj - 1);
      if (n == inj - 1) begin
        dividend = 16'd5;
        divisor = 8'd1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, n, 17);
    chk({tag, ".busycyc"}, bc, 17);
    chk({tag, ".quot"}, quot, eq);
    chk({tag, ".rem"}, rem, er);
    chk({tag, ".dz"}, dz, edz);
    chk({tag, ".ovf"}, ovf, eovf);
    chk({tag, ".busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, done, 0);
  endtask
  initial begin
    int fa[4] = '{-2, -3, 4, 12};
    int fb[4] = '{4, 6, 10, 4};
    int dcnt, bcnt;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.quot", quot, 0);
    chk("rst.rem", rem, 0);
    chk("rst.flags", {busy, done, dz, ovf}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run("20/4", 16'd20, 8'd4, 16'd5, 8'd0, 0, 0, 0);
    run("-8/4", 16'hFFF8, 8'd4, 16'hFFFE, 8'd0, 0, 0, 0);
    run("7/-2", 16'd7, 8'hFE, 16'hFFFD, 8'h01, 0, 0, 0);
    run("-7/2", 16'hFFF9, 8'h02, 16'hFFFD, 8'hFF, 0, 0, 0);
    run("-7/-2", 16'hFFF9, 8'hFE, 16'h0003, 8'hFF, 0, 0, 0);
    run("7fff/-128", 16'h7FFF, 8'h80, 16'hFF01, 8'h7F, 0, 0, 0);
    run("100/0", 16'd100, 8'd0, 16'hFFFF, 8'd100, 1, 0, 0);
    run("8000/-1", 16'h8000, 8'hFF, 16'h8000, 8'd0, 0, 1, 0);
    run("8000/2", 16'h8000, 8'd2, 16'hC000, 8'd0, 0, 0, 0);
    run("busy_start", 16'd1000, 8'd10, 16'd100, 8'd0, 0, 0, 5);
    dcnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      dcnt += int'(done);
    end
    chk("busy_start.extra_done", dcnt, 0);
    dividend = 16'd255;
    divisor = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst.quot", quot, 0);
    chk("midrst.rem", rem, 0);
    chk("midrst.flags", {busy, done, dz, ovf}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dcnt = 0;
    bcnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      dcnt += int'(done);
      bcnt += int'(busy);
    end
    chk("midrst.no_done", dcnt, 0);
    chk("midrst.idle", bcnt, 0);
    run("9/3", 16'd9, 8'd3, 16'd3, 8'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      run($sformatf("sweep%0d", i), 16'(fa[i] * fb[i]), 8'(fa[i]), 16'(fb[i]), 8'd0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
